// File: rtl/mult4_dot_acc.sv
// mult4_dot_acc: accumulates LEN multiplier products into a dot product and presents it on valid/ready (MULT4_DOT_ACC_SAT_EN selects saturation)
module mult4_dot_acc #(
    parameter int LEN = 4,
    parameter int ACC_W = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       prod,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_sum,
    output logic [7:0]       out_count,
    output logic             out_ovf
);
    typedef enum logic {ACC, HOLD} state_t;
    state_t state, next_state;
    logic [ACC_W-1:0] acc, acc_nxt;
    logic [7:0] cnt;
    logic ovf;
    logic [ACC_W:0] sum;
    logic [8:0] cnt_inc;
    logic accept, term;
    assign in_ready = state == ACC && !rst;
    assign out_valid = state == HOLD;
    assign accept = in_valid && in_ready;
    assign sum = {1'b0, acc} + (ACC_W+1)'(prod);
    assign cnt_inc = {1'b0, cnt} + 9'd1;
    assign term = in_last || cnt_inc == 9'(LEN);
`ifdef MULT4_DOT_ACC_SAT_EN
    assign acc_nxt = sum[ACC_W] ? '1 : sum[ACC_W-1:0];
`else
    assign acc_nxt = sum[ACC_W-1:0];
`endif
    // state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ACC;
        else state <= next_state;
    end
    // leave ACC on the terminating beat, leave HOLD once the result is taken
    always_comb begin
        next_state = state;
        if (state == ACC) next_state = accept && term ? HOLD : ACC;
        else next_state = out_ready ? ACC : HOLD;
    end
    // accumulate accepted products; on termination publish the result and restart from zero
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc       <= '0;
            cnt       <= '0;
            ovf       <= 1'b0;
            out_sum   <= '0;
            out_count <= '0;
            out_ovf   <= 1'b0;
        end else if (accept) begin
            if (term) begin
                acc       <= '0;
                cnt       <= '0;
                ovf       <= 1'b0;
                out_sum   <= acc_nxt;
                out_count <= cnt_inc[7:0];
                out_ovf   <= ovf | sum[ACC_W];
            end else begin
                acc <= acc_nxt;
                cnt <= cnt_inc[7:0];
                ovf <= ovf | sum[ACC_W];
            end
        end
    end
endmodule

// File: tb/tb_mult4_dot_acc.sv
// tb_mult4_dot_acc: directed checks of the dot-product accumulator (default, 9-bit and LEN=1 instances)
module tb_mult4_dot_acc;
    logic clk = 0, rst = 1;
    logic in_valid = 0, in_last = 0, out_ready = 1;
    logic [7:0] prod = 0;
    logic in_ready, out_valid, out_ovf;
    logic [11:0] out_sum;
    logic [7:0] out_count;
    logic in_ready9, out_valid9, out_ovf9;
    logic [8:0] out_sum9;
    logic [7:0] out_count9;
    logic in_valid1 = 0, in_last1 = 0, out_ready1 = 1;
    logic [7:0] prod1 = 0;
    logic in_ready1, out_valid1, out_ovf1;
    logic [11:0] out_sum1;
    logic [7:0] out_count1;
    int checks = 0, failures = 0;

    always #5 clk = ~clk;

    mult4_dot_acc dut (.clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .prod(prod),
        .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
        .out_count(out_count), .out_ovf(out_ovf));
    mult4_dot_acc #(.ACC_W(9)) dut9 (.clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready9),
        .prod(prod), .in_last(in_last), .out_valid(out_valid9), .out_ready(out_ready), .out_sum(out_sum9),
        .out_count(out_count9), .out_ovf(out_ovf9));
    mult4_dot_acc #(.LEN(1)) dut1 (.clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1),
        .prod(prod1), .in_last(in_last1), .out_valid(out_valid1), .out_ready(out_ready1), .out_sum(out_sum1),
        .out_count(out_count1), .out_ovf(out_ovf1));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // offer one beat from a falling edge; returns on the falling edge after it is accepted
    task automatic beat(input logic [7:0] p, input logic l);
        int n = 0;
        in_valid = 1;
        prod = p;
        in_last = l;
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("beat_ready", in_ready, 1);
        @(negedge clk);
        in_valid = 0;
        in_last = 0;
    endtask

    initial begin
        #1;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_sum", out_sum, 0);
        chk("rst_out_count", out_count, 0);
        chk("rst_out_ovf", out_ovf, 0);
        @(negedge clk);
        rst = 0;
        #1;
        chk("post_rst_in_ready", in_ready, 1);
        @(negedge clk);
        for (int i = 0; i < 4; i++) beat(225, 0);
        chk("v1_out_valid", out_valid, 1);
        chk("v1_in_ready", in_ready, 0);
        chk("v1_out_sum", out_sum, 900);
        chk("v1_out_count", out_count, 4);
        chk("v1_out_ovf", out_ovf, 0);
        @(negedge clk);
        chk("v1_in_ready_back", in_ready, 1);
        chk("v1_out_valid_drop", out_valid, 0);
        chk("v1_out_sum_kept", out_sum, 900);
        beat(6, 0);
        beat(9, 0);
        beat(4, 1);
        chk("v2_out_valid", out_valid, 1);
        chk("v2_out_sum", out_sum, 19);
        chk("v2_out_count", out_count, 3);
        @(negedge clk);
        out_ready = 0;
        beat(1, 0);
        beat(2, 0);
        beat(3, 0);
        beat(4, 0);
        in_valid = 1;
        prod = 7;
        for (int i = 0; i < 5; i++) begin
            chk("bp_out_valid", out_valid, 1);
            chk("bp_in_ready", in_ready, 0);
            chk("bp_out_sum", out_sum, 10);
            @(negedge clk);
        end
        out_ready = 1;
        @(negedge clk);
        chk("bp_released", in_ready, 1);
        beat(7, 0);
        beat(1, 0);
        beat(1, 0);
        beat(1, 0);
        chk("bp_next_sum", out_sum, 10);
        chk("bp_next_count", out_count, 4);
        @(negedge clk);
        for (int i = 0; i < 4; i++) beat(225, 0);
`ifdef MULT4_DOT_ACC_SAT_EN
        chk("w9_out_sum", out_sum9, 511);
`else
        chk("w9_out_sum", out_sum9, 388);
`endif
        chk("w9_out_ovf", out_ovf9, 1);
        chk("w9_out_count", out_count9, 4);
        chk("w12_out_sum", out_sum, 900);
        @(negedge clk);
        for (int i = 0; i < 4; i++) beat(1, 0);
        chk("w9_next_sum", out_sum9, 4);
        chk("w9_next_ovf", out_ovf9, 0);
        @(negedge clk);
        beat(1, 0);
        beat(1, 0);
        #3;
        rst = 1;
        #1;
        chk("arst_out_valid", out_valid, 0);
        chk("arst_out_sum", out_sum, 0);
        chk("arst_out_count", out_count, 0);
        chk("arst_in_ready", in_ready, 0);
        @(negedge clk);
        rst = 0;
        for (int i = 0; i < 4; i++) beat(1, 0);
        chk("arst_fresh_sum", out_sum, 4);
        chk("arst_fresh_count", out_count, 4);
        @(negedge clk);
        for (int x = 0; x < 16; x++) begin
            for (int y = 0; y < 16; y++) begin
                int n = 0;
                in_valid1 = 1;
                prod1 = 8'(x * y);
                while (!in_ready1 && n < 20) begin
                    @(negedge clk);
                    n++;
                end
                chk("len1_ready", in_ready1, 1);
                @(negedge clk);
                in_valid1 = 0;
                chk("len1_out_sum", out_sum1, x * y);
                chk("len1_out_count", out_count1, 1);
                chk("len1_out_ovf", out_ovf1, 0);
                @(negedge clk);
            end
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
